// File: rtl/led_rot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_rot_pkg
//  Description : Shared FSM state encoding, LED reset pattern and pattern
//                step helper for the LED rotator.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_rot_pkg;

    // Encoding 2'd3 is never entered; the FSM treats it as MAN
    typedef enum logic [1:0] {
        MAN  = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] LED_INIT = 8'h80;

    // Rotate right: bit i takes bit (i + amt) mod 8
    function automatic logic [7:0] rot_right(input logic [7:0] v, input logic [2:0] amt);
        logic [7:0] r;
        logic [2:0] idx;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            idx  = 3'(i) + amt;
            r[i] = v[idx];
        end
        return r;
    endfunction

    // A zero amount reloads the pattern instead of rotating
    function automatic logic [7:0] next_pattern(input logic [7:0] v, input logic [2:0] amt);
        return (amt == 3'd0) ? LED_INIT : rot_right(v, amt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_rot_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, counter debouncer and rising-edge
//                detector for a raw push-button. Emits a one-cycle press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYC = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [19:0] c_CNT_LAST = 20'(DEB_CYC - 1);

    logic [1:0]  r_sync;
    logic [1:0]  r_vld;    // fills with ones once the synchronizer holds real samples
    logic        r_armed;  // set once the button is seen released after reset
    logic        r_level;
    logic [19:0] r_cnt;
    logic        r_press;

    assign press = r_press;

    // Synchronize, debounce, and flag an armed debounced rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_vld   <= {r_vld[0], 1'b1};
            r_press <= 1'b0;
            // A button held through reset must be released before it can press
            if (r_vld[1] && !r_sync[1]) begin
                r_armed <= 1'b1;
            end
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1] & r_armed;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_rot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_rot_ctrl
//  Description : Rotating LED pattern with manual (button) or automatic
//                (prescaled) stepping and a hold/resume function.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_rot_ctrl
    import led_rot_pkg::*;
#(
    parameter int PRESCALE = 12_500_000,
    parameter int DEB_CYC  = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       br,
    input  logic [2:0] sw,
    input  logic       mode,
    output logic [7:0] ledr,
    output logic       step,
    output logic [1:0] state
);

    localparam logic [23:0] c_PRE_LAST = 24'(PRESCALE - 1);

    logic        w_press;
    logic [1:0]  r_mode_sync;
    logic        w_mode;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_pre;
    logic [23:0] w_pre_nxt;
    logic        w_do_step;
    logic [7:0]  r_ledr;
    logic        r_step;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (br),
        .press   (w_press)
    );

    assign w_mode = r_mode_sync[1];
    assign ledr   = r_ledr;
    assign step   = r_step;
    assign state  = r_state;

    // State, prescaler, pattern and step-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_sync <= 2'b00;
            r_state     <= MAN;
            r_pre       <= '0;
            r_ledr      <= LED_INIT;
            r_step      <= 1'b0;
        end else begin
            r_mode_sync <= {r_mode_sync[0], mode};
            r_state     <= w_state_nxt;
            r_pre       <= w_pre_nxt;
            r_step      <= w_do_step;
            if (w_do_step) begin
                r_ledr <= next_pattern(r_ledr, sw);
            end
        end
    end

    // Next state; a mode change outranks a press, a press outranks terminal count
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_do_step   = 1'b0;
        case (r_state)
            MAN: begin
                if (w_mode) begin
                    w_state_nxt = RUN;
                    w_pre_nxt   = '0;
                end else if (w_press) begin
                    w_do_step = 1'b1;
                end
            end
            RUN: begin
                if (!w_mode) begin
                    w_state_nxt = MAN;
                    w_pre_nxt   = '0;
                end else if (w_press) begin
                    w_state_nxt = HOLD;
                end else if (r_pre == c_PRE_LAST) begin
                    w_pre_nxt = '0;
                    w_do_step = 1'b1;
                end else begin
                    w_pre_nxt = r_pre + 24'd1;
                end
            end
            HOLD: begin
                if (!w_mode) begin
                    w_state_nxt = MAN;
                    w_pre_nxt   = '0;
                end else if (w_press) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = MAN;
                w_pre_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/led_rot_ctrl.md
LED_ROT_CTRL -- requirements
Module: led_rot_ctrl

Interface
REQ-001 Parameter PRESCALE, default 12_500_000: clock cycles between auto steps; legal range 2 to 2^24-1.
REQ-002 Parameter DEB_CYC, default 250_000: consecutive stable cycles required to accept a button level change; legal range 2 to 2^20-1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port br, input, 1 bit: raw asynchronous push-button, active-high.
REQ-006 Port sw, input, 3 bits: rotate amount; 0 means reload the pattern.
REQ-007 Port mode, input, 1 bit: 0 = manual stepping, 1 = automatic stepping; asynchronous slide switch.
REQ-008 Port ledr, output, 8 bits: rotating LED pattern, registered.
REQ-009 Port step, output, 1 bit: one-cycle pulse, high in the cycle ledr takes its new value.
REQ-010 Port state, output, 2 bits: current FSM state encoding.

Function
REQ-011 br and mode SHALL each pass through a two-flop synchronizer before use.
REQ-012 The synchronized br SHALL be debounced: the debounced level changes only after DEB_CYC consecutive equal samples; any differing sample restarts the count.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced 0->1 edge; release generates nothing.
REQ-014 A step SHALL set ledr to 8'h80 when sw==0; otherwise ledr rotates right by sw (bit i receives bit (i+sw) mod 8). sw is sampled in the step cycle.
REQ-015 The FSM SHALL have states MAN=0, RUN=1, HOLD=2; encoding 3 is unreachable and recovers to MAN on the next clock.
REQ-016 MAN: each press event causes one step; synchronized mode=1 moves to RUN with the prescaler at 0.
REQ-017 RUN: the prescaler counts 0..PRESCALE-1 and wraps; the step occurs when the count equals PRESCALE-1; a press event moves to HOLD.
REQ-018 HOLD: the prescaler and ledr are frozen; a press event returns to RUN, and counting resumes from the frozen value.
REQ-019 In RUN or HOLD, synchronized mode=0 moves to MAN and clears the prescaler.
REQ-020 When a press event and a prescaler terminal count coincide in RUN: go to HOLD, no step, prescaler frozen at PRESCALE-1.
REQ-021 When a mode change and a press event coincide: take the mode transition and discard the press.
REQ-022 Step latency: ledr and step SHALL update on the clock edge following the press event or terminal-count cycle (one cycle).
REQ-023 At most one step SHALL occur per clock cycle.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL set: ledr=8'h80, step=0, state=MAN, prescaler=0, debounce counter=0, debounced level=0, and all synchronizer flops=0.
REQ-025 Reset asserted mid-debounce or mid-prescale SHALL discard the partial count; a button held through reset SHALL NOT produce a press event until it has been released and pressed again.

Structure
REQ-026 Shared package led_rot_pkg SHALL hold the state encoding (MAN, RUN, HOLD) and the constant LED_INIT=8'h80.
REQ-027 The synchronizer, debouncer and edge detector SHALL be sub-module btn_debounce (ports clk, rst, btn_raw, press), instantiated once.

Verification (PRESCALE=4, DEB_CYC=3)
REQ-028 Check reset: ledr=8'h80, state=0 the cycle after rst; mode=0; sw=1; a clean press -> ledr=8'h40 with step high for exactly 1 cycle.
REQ-029 Check bounce rejection: br toggling every cycle for 10 cycles, then steady high -> exactly one step; a 2-cycle glitch -> no step.
REQ-030 Check auto mode: mode=1, sw=3, start 8'h80 -> ledr 8'h10, 8'h02, 8'h40 at 4-cycle intervals, with step pulsing every 4th cycle.
REQ-031 Check hold and resume: press in RUN -> state=2 and ledr frozen for 20 cycles; a second press -> state=1 and the next step arrives after the remaining count.
REQ-032 Check the coincidence rules: a press aligned with terminal count -> HOLD and no step; mode 1->0 aligned with a press -> MAN and no step.
REQ-033 Check sw=0 and sw=7: sw=0 step from 8'h01 -> 8'h80; sw=7 step from 8'h80 -> 8'h01.
